multicycle_control: RTL and testbench

- Multicycle FSM control unit; generalised successor of the single-cycle opcode decoder.
- Sequences each RV32I subset instruction over 3–5 states.
- Stalls on a memory ready handshake, traps on illegal opcodes and counts retired instructions.
- Sits between the instruction register opcode field and the multicycle datapath muxes and enables.

---
 rtl/multicycle_control_pkg.sv | 55 +++++
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control_retire_counter.sv | 19 +
 rtl/multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, states, mux selects.
package multicycle_control_pkg;

  // RV32I subset opcodes (7-bit, zero-extended at point of use)
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // FSM state encodings (visible on oState)
  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC_R = 4'd6;
  localparam logic [3:0] ST_ALUWB  = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_EXEC_I = 4'd9;
  localparam logic [3:0] ST_JAL    = 4'd10;
  localparam logic [3:0] ST_TRAP   = 4'd15;

  // ALU operand / op / PC source selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;

  // Bundle of combinational datapath controls
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle. slave = control unit, master = datapath side.
interface multicycle_control_if #(
  parameter int OPC_WIDTH = 7,
  parameter int CNT_WIDTH = 32
);
  logic [OPC_WIDTH-1:0] iOPCODE;
  logic                 iMEM_READY;
  logic                 oPCWrite;
  logic                 oPCWriteCond;
  logic                 oIRWrite;
  logic                 oIorD;
  logic                 oMemRead;
  logic                 oMemWrite;
  logic                 oRegWrite;
  logic                 oMemtoReg;
  logic [1:0]           oALUSrcA;
  logic [1:0]           oALUSrcB;
  logic [1:0]           oALUOp;
  logic [1:0]           oPCSource;
  logic [3:0]           oState;
  logic                 oIllegal;
  logic [CNT_WIDTH-1:0] oRetired;

  modport slave (
    input  iOPCODE, iMEM_READY,
    output oPCWrite, oPCWriteCond, oIRWrite, oIorD, oMemRead, oMemWrite,
           oRegWrite, oMemtoReg, oALUSrcA, oALUSrcB, oALUOp, oPCSource,
           oState, oIllegal, oRetired
  );

  modport master (
    output iOPCODE, iMEM_READY,
    input  oPCWrite, oPCWriteCond, oIRWrite, oIorD, oMemRead, oMemWrite,
           oRegWrite, oMemtoReg, oALUSrcA, oALUSrcB, oALUOp, oPCSource,
           oState, oIllegal, oRetired
  );
endinterface

// File: rtl/multicycle_control_retire_counter.sv
// Wrapping retired-instruction counter; no overflow flag by design.
module mc_retire_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);
  logic [WIDTH-1:0] r_cnt;

  // Count retirements, wrapping modulo 2^WIDTH
  always_ff @(posedge i_clk) begin
    if (i_rst)      r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + WIDTH'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I-subset control FSM: sequences states, stalls on memory ready,
// traps on illegal opcodes or memory timeout, counts retired instructions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPC_WIDTH   = 7,
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                iCLK,
  input  logic                iRST,
  multicycle_control_if.slave bus
);
  localparam logic [OPC_WIDTH-1:0] L_LOAD   = OPC_WIDTH'(OPC_LOAD);
  localparam logic [OPC_WIDTH-1:0] L_STORE  = OPC_WIDTH'(OPC_STORE);
  localparam logic [OPC_WIDTH-1:0] L_RTYPE  = OPC_WIDTH'(OPC_RTYPE);
  localparam logic [OPC_WIDTH-1:0] L_OPIMM  = OPC_WIDTH'(OPC_OPIMM);
  localparam logic [OPC_WIDTH-1:0] L_BRANCH = OPC_WIDTH'(OPC_BRANCH);
  localparam logic [OPC_WIDTH-1:0] L_JAL    = OPC_WIDTH'(OPC_JAL);

  // Timeout counter only needs to hold 0..MEM_TIMEOUT-1
  localparam int            TW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  logic [3:0]    r_state, w_next;
  logic          r_is_store;
  logic [TW-1:0] r_tmo;
  logic          r_illegal;
  logic          w_wait, w_tmo_hit, w_retire;
  ctrl_t         w_c;

  assign w_wait = ((r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR))
                  && !bus.iMEM_READY;
  assign w_tmo_hit = (MEM_TIMEOUT > 0) && w_wait && (r_tmo == TMO_LAST);

  // Final-state exits back to FETCH retire one instruction
  assign w_retire = ((r_state == ST_MEMWR) && bus.iMEM_READY) || (r_state == ST_MEMWB) ||
                    (r_state == ST_ALUWB) || (r_state == ST_BRANCH) || (r_state == ST_JAL);

  // Next-state decode; unused encodings fall into TRAP
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:  if (bus.iMEM_READY) w_next = ST_DECODE;
      ST_DECODE: begin
        if ((bus.iOPCODE == L_LOAD) || (bus.iOPCODE == L_STORE)) w_next = ST_MEMADR;
        else if (bus.iOPCODE == L_RTYPE)  w_next = ST_EXEC_R;
        else if (bus.iOPCODE == L_OPIMM)  w_next = ST_EXEC_I;
        else if (bus.iOPCODE == L_BRANCH) w_next = ST_BRANCH;
        else if (bus.iOPCODE == L_JAL)    w_next = ST_JAL;
        else                              w_next = ST_TRAP;
      end
      ST_MEMADR: w_next = r_is_store ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  if (bus.iMEM_READY) w_next = ST_MEMWB;
      ST_MEMWR:  if (bus.iMEM_READY) w_next = ST_FETCH;
      ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JAL: w_next = ST_FETCH;
      ST_EXEC_R, ST_EXEC_I:                  w_next = ST_ALUWB;
      default:   w_next = ST_TRAP;
    endcase
    if (w_tmo_hit) w_next = ST_TRAP;
  end

  // State register plus load/store flavour captured while the opcode is valid
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state    <= ST_FETCH;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_is_store <= (bus.iOPCODE == L_STORE);
    end
  end

  // Consecutive not-ready cycles within one memory state
  always_ff @(posedge iCLK) begin
    if (iRST)                                                  r_tmo <= '0;
    else if ((MEM_TIMEOUT > 0) && w_wait && (w_next == r_state)) r_tmo <= r_tmo + TW'(1);
    else                                                       r_tmo <= '0;
  end

  // Sticky trap flag, raised once the FSM sits in TRAP
  always_ff @(posedge iCLK) begin
    if (iRST)                      r_illegal <= 1'b0;
    else if (r_state == ST_TRAP)   r_illegal <= 1'b1;
  end

  mc_retire_counter #(.WIDTH(CNT_WIDTH)) u_retire (
    .i_clk (iCLK),
    .i_rst (iRST),
    .i_inc (w_retire),
    .o_cnt (bus.oRetired)
  );

  // Per-state strobes; reset forces everything quiet
  always_comb begin
    w_c = '0;
    case (r_state)
      ST_FETCH: begin
        w_c.mem_read  = 1'b1;
        w_c.alu_src_a = SRCA_PC;
        w_c.alu_src_b = SRCB_FOUR;
        w_c.alu_op    = ALUOP_ADD;
        w_c.pc_source = PCSRC_ALU;
        w_c.ir_write  = bus.iMEM_READY;
        w_c.pc_write  = bus.iMEM_READY;
      end
      ST_DECODE: begin
        w_c.alu_src_a = SRCA_OLDPC;
        w_c.alu_src_b = SRCB_IMM;
        w_c.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        w_c.alu_src_a = SRCA_RS1;
        w_c.alu_src_b = SRCB_IMM;
        w_c.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        w_c.mem_read = 1'b1;
        w_c.iord     = 1'b1;
      end
      ST_MEMWR: begin
        w_c.mem_write = 1'b1;
        w_c.iord      = 1'b1;
      end
      ST_MEMWB: begin
        w_c.reg_write  = 1'b1;
        w_c.mem_to_reg = 1'b1;
      end
      ST_EXEC_R: begin
        w_c.alu_src_a = SRCA_RS1;
        w_c.alu_src_b = SRCB_RS2;
        w_c.alu_op    = ALUOP_FUNC;
      end
      ST_EXEC_I: begin
        w_c.alu_src_a = SRCA_RS1;
        w_c.alu_src_b = SRCB_IMM;
        w_c.alu_op    = ALUOP_FUNC;
      end
      ST_ALUWB: w_c.reg_write = 1'b1;
      ST_BRANCH: begin
        w_c.alu_src_a     = SRCA_RS1;
        w_c.alu_src_b     = SRCB_RS2;
        w_c.alu_op        = ALUOP_SUB;
        w_c.pc_write_cond = 1'b1;
        w_c.pc_source     = PCSRC_OUT;
      end
      ST_JAL: begin
        w_c.pc_write  = 1'b1;
        w_c.pc_source = PCSRC_OUT;
        w_c.reg_write = 1'b1;
        w_c.alu_src_a = SRCA_OLDPC;
        w_c.alu_src_b = SRCB_FOUR;
      end
      default: w_c = '0;
    endcase
    if (iRST) w_c = '0;
  end

  assign bus.oPCWrite     = w_c.pc_write;
  assign bus.oPCWriteCond = w_c.pc_write_cond;
  assign bus.oIRWrite     = w_c.ir_write;
  assign bus.oIorD        = w_c.iord;
  assign bus.oMemRead     = w_c.mem_read;
  assign bus.oMemWrite    = w_c.mem_write;
  assign bus.oRegWrite    = w_c.reg_write;
  assign bus.oMemtoReg    = w_c.mem_to_reg;
  assign bus.oALUSrcA     = w_c.alu_src_a;
  assign bus.oALUSrcB     = w_c.alu_src_b;
  assign bus.oALUOp       = w_c.alu_op;
  assign bus.oPCSource    = w_c.pc_source;
  assign bus.oState       = r_state;
  assign bus.oIllegal     = r_illegal;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: dut0 default params, dut1 with CNT_WIDTH=3 and MEM_TIMEOUT=4,
// both driven by the same opcode/ready/reset stimulus.
module tb_multicycle_control;
  logic       clk;
  logic       rst;
  logic [6:0] opc;
  logic       rdy;
  int         n_cmp;
  int         n_bad;

  localparam logic [6:0] ADD = 7'h33, LD = 7'h03, ST = 7'h23, BEQ = 7'h63;
  localparam logic [6:0] OPI = 7'h13, JL = 7'h6F, BAD = 7'h7F;

  multicycle_control_if #(.OPC_WIDTH(7), .CNT_WIDTH(32)) if0 ();
  multicycle_control_if #(.OPC_WIDTH(7), .CNT_WIDTH(3))  if1 ();

  assign if0.iOPCODE    = opc;
  assign if0.iMEM_READY = rdy;
  assign if1.iOPCODE    = opc;
  assign if1.iMEM_READY = rdy;

  multicycle_control #(.OPC_WIDTH(7), .CNT_WIDTH(32), .MEM_TIMEOUT(0)) dut0 (
    .iCLK (clk), .iRST (rst), .bus (if0.slave));
  multicycle_control #(.OPC_WIDTH(7), .CNT_WIDTH(3), .MEM_TIMEOUT(4)) dut1 (
    .iCLK (clk), .iRST (rst), .bus (if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCW, PCWC, IRW, IorD, MR, MW, RW, M2R, SrcA, SrcB, ALUOp, PCSrc}
  logic [15:0] strb0;
  assign strb0 = {if0.oPCWrite, if0.oPCWriteCond, if0.oIRWrite, if0.oIorD,
                  if0.oMemRead, if0.oMemWrite, if0.oRegWrite, if0.oMemtoReg,
                  if0.oALUSrcA, if0.oALUSrcB, if0.oALUOp, if0.oPCSource};

  typedef struct {
    logic        rst;
    logic [6:0]  opc;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] strb;
    int          ret;
    int          ill;   // -1 = not checked
  } vec_t;

  vec_t tbl[40];
  int   nv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic v(input logic r, input logic [6:0] o, input logic y, input logic [3:0] s,
                   input logic [15:0] b, input int rt, input int il);
    tbl[nv] = '{rst: r, opc: o, rdy: y, st: s, strb: b, ret: rt, ill: il};
    nv++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; nv = 0;
    rst = 1'b1; opc = ADD; rdy = 1'b1;

    // reset hold, then add (R-type)
    v(1, ADD, 1,  0, 16'h0000, 0, 0);
    v(0, ADD, 1,  0, 16'hA810, 0, 0);
    v(0, ADD, 1,  1, 16'h00A0, 0, 0);
    v(0, ADD, 1,  6, 16'h0048, 0, 0);
    v(0, ADD, 1,  7, 16'h0200, 0, 0);
    // load with 3 wait states in MEMRD
    v(0, LD,  1,  0, 16'hA810, 1, 0);
    v(0, LD,  1,  1, 16'h00A0, 1, 0);
    v(0, LD,  1,  2, 16'h0060, 1, 0);
    v(0, LD,  0,  3, 16'h1800, 1, 0);
    v(0, LD,  0,  3, 16'h1800, 1, 0);
    v(0, LD,  0,  3, 16'h1800, 1, 0);
    v(0, LD,  1,  3, 16'h1800, 1, 0);
    v(0, LD,  1,  4, 16'h0300, 1, 0);
    // store
    v(0, ST,  1,  0, 16'hA810, 2, 0);
    v(0, ST,  1,  1, 16'h00A0, 2, 0);
    v(0, ST,  1,  2, 16'h0060, 2, 0);
    v(0, ST,  1,  5, 16'h1400, 2, 0);
    // beq
    v(0, BEQ, 1,  0, 16'hA810, 3, 0);
    v(0, BEQ, 1,  1, 16'h00A0, 3, 0);
    v(0, BEQ, 1,  8, 16'h4045, 3, 0);
    // addi
    v(0, OPI, 1,  0, 16'hA810, 4, 0);
    v(0, OPI, 1,  1, 16'h00A0, 4, 0);
    v(0, OPI, 1,  9, 16'h0068, 4, 0);
    v(0, OPI, 1,  7, 16'h0200, 4, 0);
    // jal
    v(0, JL,  1,  0, 16'hA810, 5, 0);
    v(0, JL,  1,  1, 16'h00A0, 5, 0);
    v(0, JL,  1, 10, 16'h8291, 5, 0);
    // one fetch wait, then illegal opcode -> TRAP, then reset out of it
    v(0, BAD, 0,  0, 16'h0810, 6, 0);
    v(0, BAD, 1,  0, 16'hA810, 6, 0);
    v(0, BAD, 1,  1, 16'h00A0, 6, 0);
    v(0, BAD, 1, 15, 16'h0000, 6, -1);
    v(0, BAD, 1, 15, 16'h0000, 6, 1);
    v(0, BAD, 0, 15, 16'h0000, 6, 1);
    v(1, BAD, 0, 15, 16'h0000, 6, 1);
    // reset in the middle of a load
    v(0, LD,  1,  0, 16'hA810, 0, 0);
    v(0, LD,  1,  1, 16'h00A0, 0, 0);
    v(0, LD,  1,  2, 16'h0060, 0, 0);
    v(0, LD,  0,  3, 16'h1800, 0, 0);
    v(1, LD,  0,  3, 16'h0000, 0, 0);
    v(0, ADD, 1,  0, 16'hA810, 0, 0);

    tick();  // initial reset edge
    for (int i = 0; i < nv; i++) begin
      rst = tbl[i].rst; opc = tbl[i].opc; rdy = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d state", i),     {28'd0, if0.oState}, {28'd0, tbl[i].st});
      chk($sformatf("v%0d state1", i),    {28'd0, if1.oState}, {28'd0, tbl[i].st});
      chk($sformatf("v%0d strobes", i),   {16'd0, strb0},      {16'd0, tbl[i].strb});
      chk($sformatf("v%0d retired", i),   if0.oRetired,        tbl[i].ret);
      if (tbl[i].ill >= 0)
        chk($sformatf("v%0d illegal", i), {31'd0, if0.oIllegal}, tbl[i].ill);
      tick();
    end

    // 9 back-to-back adds: 32-bit counter reaches 9, 3-bit counter wraps to 1
    rst = 1'b1; tick();
    rst = 1'b0; opc = ADD; rdy = 1'b1;
    for (int k = 0; k < 32; k++) tick();
    chk("wrap ret0 after 8", if0.oRetired, 32'd8);
    chk("wrap ret1 after 8", {29'd0, if1.oRetired}, 32'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("wrap ret0 after 9", if0.oRetired, 32'd9);
    chk("wrap ret1 after 9", {29'd0, if1.oRetired}, 32'd1);
    chk("wrap state1", {28'd0, if1.oState}, 32'd0);

    // fetch stuck not-ready: dut1 traps after 4 cycles, dut0 just waits
    rst = 1'b1; tick();
    rst = 1'b0; rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("tmo c%0d state1", k), {28'd0, if1.oState}, 32'd0);
      chk($sformatf("tmo c%0d irw1", k),   {31'd0, if1.oIRWrite}, 32'd0);
      tick();
    end
    chk("tmo trap state1", {28'd0, if1.oState}, 32'd15);
    chk("tmo hold state0", {28'd0, if0.oState}, 32'd0);
    tick();
    chk("tmo illegal1", {31'd0, if1.oIllegal}, 32'd1);
    chk("tmo illegal0", {31'd0, if0.oIllegal}, 32'd0);
    rdy = 1'b1; #1;
    chk("tmo irw1 ready", {31'd0, if1.oIRWrite}, 32'd0);
    chk("tmo irw0 ready", {31'd0, if0.oIRWrite}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
